// File: rtl/flag_unit_if.sv
// Interface bundling the decode/ALU-side signals of flag_unit.
// master drives the requests and ALU data; slave (flag_unit) returns flags and stall.
interface flag_unit_if #(
  parameter int WIDTH = 24
);
  logic             issue_valid;
  logic             issue_setflags;
  logic             br_req;
  logic             alu_valid;
  logic             alu_setflags;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       Flags;
  logic             flags_stall;
  logic             flag_err;

  modport master (
    output issue_valid, issue_setflags, br_req,
    output alu_valid, alu_setflags, alu_op, alu_a, alu_b, alu_result,
    input  Flags, flags_stall, flag_err
  );

  modport slave (
    input  issue_valid, issue_setflags, br_req,
    input  alu_valid, alu_setflags, alu_op, alu_a, alu_b, alu_result,
    output Flags, flags_stall, flag_err
  );
endinterface

// File: rtl/flag_unit.sv
// Condition-flag register {carry, neg, zero, overflow} with pending-setter tracking and branch stall.
// Optional macro FLAGS_FWD_EN forwards the flag write and releases the stall in the fw cycle.
module flag_unit #(
  parameter int WIDTH      = 24,
  parameter int PIPE_DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  flag_unit_if.slave bus
);
  localparam int PW = $clog2(PIPE_DEPTH + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(PIPE_DEPTH);

  logic             fw;
  logic             inc;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [3:0]       flags_q, flags_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic             err_q, err_d;
  logic [PW-1:0]    pend_after;

  assign fw  = bus.alu_valid && bus.alu_setflags;
  assign inc = bus.issue_valid && bus.issue_setflags;

  assign add_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign sub_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    flags_d = flags_q;
    if (fw) begin
      case (bus.alu_op)
        2'b00: flags_d = {add_s[WIDTH], add_s[WIDTH-1], (add_s[WIDTH-1:0] == '0),
                          (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                          (add_s[WIDTH-1] != bus.alu_a[WIDTH-1])};
        2'b01: flags_d = {sub_s[WIDTH], sub_s[WIDTH-1], (sub_s[WIDTH-1:0] == '0),
                          (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                          (sub_s[WIDTH-1] != bus.alu_a[WIDTH-1])};
        2'b10: flags_d = {flags_q[3], bus.alu_result[WIDTH-1],
                          (bus.alu_result == '0), flags_q[0]};
        default: flags_d = bus.alu_b[3:0];
      endcase
    end
  end

  // Out-of-range steps hold the count and latch the sticky error.
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    if (inc && !fw) begin
      if (pend_q == PEND_MAX) err_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (fw && !inc) begin
      if (pend_q == '0) err_d = 1'b1;
      else              pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign pend_after   = pend_q - PW'(fw);
  assign bus.flag_err = err_q;

`ifdef FLAGS_FWD_EN
  assign bus.Flags       = fw ? flags_d : flags_q;
  assign bus.flags_stall = bus.br_req && (pend_after != '0);
`else
  assign bus.Flags       = flags_q;
  assign bus.flags_stall = bus.br_req && (pend_q != '0);
`endif
endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: arithmetic reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_flag_unit;
  localparam int W     = 24;
  localparam int DEPTH = 3;
  localparam int PW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  flag_unit_if #(.WIDTH(W)) bus ();
  flag_unit #(.WIDTH(W), .PIPE_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] m_flags;
  int         m_pend;
  logic       m_err;

  function automatic logic [3:0] next_flags(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] r,
                                            input logic [3:0] cur);
    longint m = longint'(1) << W;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= m/2) ? ua - m : ua;
    longint sb = (ub >= m/2) ? ub - m : ub;
    longint res, ss;
    logic c;
    case (op)
      2'b00: begin res = (ua + ub) % m; c = (ua + ub) >= m; ss = sa + sb; end
      2'b01: begin res = (ua - ub + m) % m; c = (ua >= ub); ss = sa - sb; end
      2'b10: begin
        return {cur[3], (longint'(r) >= m/2), (r == 0), cur[0]};
      end
      default: return b[3:0];
    endcase
    return {c, (res >= m/2), (res == 0), (ss >= m/2) || (ss < -(m/2))};
  endfunction

  wire m_fw  = bus.alu_valid && bus.alu_setflags;
  wire m_inc = bus.issue_valid && bus.issue_setflags;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_flags = 4'b0000; m_pend = 0; m_err = 1'b0;
    end else begin
      if (m_fw) m_flags = next_flags(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_result, m_flags);
      if (m_inc && !m_fw) begin
        if (m_pend == DEPTH) m_err = 1'b1; else m_pend = m_pend + 1;
      end else if (m_fw && !m_inc) begin
        if (m_pend == 0) m_err = 1'b1; else m_pend = m_pend - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ef;
    logic       es;
    int         pa;
`ifdef FLAGS_FWD_EN
    ef = m_fw ? next_flags(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_result, m_flags) : m_flags;
    pa = (m_pend - int'(m_fw) + (1 << PW)) % (1 << PW);
`else
    ef = m_flags;
    pa = m_pend;
`endif
    es = bus.br_req && (pa != 0);
    chk("model_flags", int'(bus.Flags), int'(ef));
    chk("model_stall", int'(bus.flags_stall), int'(es));
    chk("model_err",   int'(bus.flag_err), int'(m_err));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_setflags = 0; bus.br_req = 0;
    bus.alu_valid = 0; bus.alu_setflags = 0; bus.alu_op = 2'b00;
    bus.alu_a = '0; bus.alu_b = '0; bus.alu_result = '0;
  endtask

  task automatic issue();
    bus.issue_valid = 1; bus.issue_setflags = 1;
  endtask

  task automatic alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r);
    bus.alu_valid = 1; bus.alu_setflags = 1; bus.alu_op = op;
    bus.alu_a = a; bus.alu_b = b; bus.alu_result = r;
  endtask

  // Issue a setter, execute it next cycle, then check the registered flags.
  task automatic setter(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic [3:0] exp);
    idle(); issue(); tick();
    idle(); alu(op, a, b, r); tick();
    idle(); #1;
    chk(name, int'(bus.Flags), int'(exp));
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    bus.br_req = 1; #1;
    chk("reset_flags", int'(bus.Flags), 0);
    chk("reset_stall", int'(bus.flags_stall), 0);
    chk("reset_err",   int'(bus.flag_err), 0);
    tick();

    setter("add_ovf",   2'b00, 24'h7FFFFF, 24'h000001, '0, 4'b0101);
    setter("sub_eq",    2'b01, 24'd5, 24'd5, '0, 4'b1010);
    setter("sub_borrow",2'b01, 24'd3, 24'd5, '0, 4'b0100);
    setter("sub_ovf",   2'b01, 24'h800000, 24'd1, '0, 4'b1001);
    setter("restore",   2'b11, '0, 24'h00000B, '0, 4'b1011);
    setter("logic_zero",2'b10, '0, '0, 24'h000000, 4'b1011);
    setter("logic_neg", 2'b10, '0, '0, 24'h800001, 4'b1101);
    chk("no_err_yet", int'(bus.flag_err), 0);

    // Branch behind a setter: issue at 0, br_req from 1, fw at 3.
    idle(); issue(); tick();
    idle(); bus.br_req = 1; #1; chk("stall_c1", int'(bus.flags_stall), 1); tick();
    idle(); bus.br_req = 1; #1; chk("stall_c2", int'(bus.flags_stall), 1); tick();
    idle(); bus.br_req = 1; alu(2'b00, 24'd1, 24'd1, '0); #1;
`ifdef FLAGS_FWD_EN
    chk("stall_c3", int'(bus.flags_stall), 0);
    chk("fwd_flags_c3", int'(bus.Flags), 0);
`else
    chk("stall_c3", int'(bus.flags_stall), 1);
    chk("reg_flags_c3", int'(bus.Flags), 4'b1101);
`endif
    tick();
    idle(); bus.br_req = 1; #1;
    chk("stall_c4", int'(bus.flags_stall), 0);
    chk("flags_c4", int'(bus.Flags), 0);
    tick();

    // Simultaneous issue and fw at pend=1.
    idle(); issue(); tick();
    idle(); issue(); bus.br_req = 1; alu(2'b11, '0, 24'h3, '0); tick();
    idle(); bus.br_req = 1; #1;
    chk("pend_hold_stall", int'(bus.flags_stall), 1);
    chk("pend_hold_err",   int'(bus.flag_err), 0);
    // Four more issues from pend=1 overflow the counter.
    for (int unsigned i = 0; i < 4; i++) begin idle(); issue(); tick(); end
    idle(); bus.br_req = 1; #1;
    chk("ovf_err",   int'(bus.flag_err), 1);
    chk("ovf_stall", int'(bus.flags_stall), 1);
    // Saturated at 3: two drains leave it pending, the third empties it.
    for (int unsigned i = 0; i < 2; i++) begin idle(); alu(2'b10, '0, '0, 24'h1); tick(); end
    idle(); bus.br_req = 1; #1; chk("sat_pend1", int'(bus.flags_stall), 1);
    idle(); alu(2'b10, '0, '0, 24'h1); tick();
    idle(); bus.br_req = 1; #1; chk("sat_pend0", int'(bus.flags_stall), 0);
    tick();

    // Underflow: fw at pend=0 still writes flags.
    reset = 1; tick(); reset = 0;
    idle(); alu(2'b11, '0, 24'h5, '0); tick();
    idle(); #1;
    chk("udf_err",   int'(bus.flag_err), 1);
    chk("udf_flags", int'(bus.Flags), 4'b0101);
    bus.br_req = 1; #1;
    chk("udf_stall", int'(bus.flags_stall), 0);

    // Mid-stream reset with a setter in flight.
    idle(); issue(); tick();
    idle(); bus.br_req = 1; #1;
    chk("pre_rst_stall", int'(bus.flags_stall), 1);
    reset = 1; #1;
    chk("rst_flags", int'(bus.Flags), 0);
    chk("rst_stall", int'(bus.flags_stall), 0);
    chk("rst_err",   int'(bus.flag_err), 0);
    tick();
    reset = 0; tick();
    chk("post_rst_stall", int'(bus.flags_stall), 0);
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
